shl_iter_32: RTL

// Multi-cycle logical left shifter (toward bit 31, zero fill): the opposite direction of the SHR_x stage set.

---
 rtl/shl_iter_32.sv | 77 +++++++
 1 files changed

// File: rtl/shl_iter_32.sv
// Multi-cycle logical left shifter: one binary stage per clock (16, 8, 4, 2, 1),
// with valid/ready on both sides and a flag for any 1 bit shifted out of the top.
module shl_iter_32 #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lost,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] data;
  logic [SHW-1:0]   amt;
  logic [SHW-1:0]   stage;
  logic             lost;
  logic [SHW-1:0]   s;
  logic [WIDTH-1:0] top_mask;

  // s = 2**stage never exceeds WIDTH/2, so it fits in SHW bits.
  assign s        = SHW'(1) << stage;
  assign top_mask = ~({WIDTH{1'b1}} >> s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      amt   <= '0;
      stage <= '0;
      lost  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= in_data;
            amt   <= in_amt;
            lost  <= 1'b0;
            stage <= SHW'(SHW - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (amt[stage]) begin
            data <= data << s;
            lost <= lost | (|(data & top_mask));
          end
          // Every amount walks all stages so latency is constant.
          if (stage == '0) state <= DONE;
          else             stage <= stage - SHW'(1);
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = data;
  assign out_lost  = lost;

endmodule
